vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter PRICE1, default 8'd15: price of product 1 in cents.
REQ-002 SHALL have parameter PRICE2, default 8'd25: price of product 2 in cents.
REQ-003 SHALL have parameter PRICE3, default 8'd30: price of product 3 in cents.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000: COLLECT inactivity limit.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port sel_valid  input  1  one-cycle product-select strobe.
REQ-008 SHALL have port sel_id  input  2  requested product: 00/01/10 valid, 11 invalid.
REQ-009 SHALL have port coin_valid  input  1  one-cycle coin strobe.
REQ-010 SHALL have port coin_code  input  2  coin encoding: 00=5, 01=10, 10=25, 11=invalid.
REQ-011 SHALL have port cancel  input  1  user abort request.
REQ-012 SHALL have ports prod1_count, prod2_count, prod3_count  input  4 each  current stock.
REQ-013 SHALL have port product_sel  output  2  product index driven to the inventory update.
REQ-014 SHALL have port update_inventory  output  1  one-cycle decrement strobe.
REQ-015 SHALL have port dispense  output  1  one-cycle dispense strobe, coincident with update_inventory.
REQ-016 SHALL have ports change_valid  output  1  and change_amount  output  8  change/refund strobe and value.
REQ-017 SHALL have ports coin_reject  output  1  and sold_out  output  1  one-cycle status strobes.
REQ-018 SHALL have port credit  output  8  registered accumulated credit.

Function
REQ-019 SHALL implement states IDLE, COLLECT, VEND, CHANGE, REFUND.
REQ-020 IDLE: sel_valid with valid sel_id and stock>0 -> latch product_sel and price, go COLLECT next edge.
REQ-021 IDLE: sel_valid with sel_id=11 or stock=0 -> sold_out high one cycle, stay IDLE.
REQ-022 Coins SHALL be accepted only in IDLE and COLLECT; credit updates on the accepting edge.
REQ-023 coin_code=11, coin in VEND/CHANGE/REFUND, or credit+value>255 -> coin_reject one cycle, credit unchanged.
REQ-024 COLLECT: registered credit>=price -> VEND on next edge (one cycle after credit reaches price).
REQ-025 On VEND entry, stock of latched product =0 -> REFUND instead; else update_inventory=dispense=1 for exactly one cycle.
REQ-026 VEND -> CHANGE unconditionally; CHANGE drives change_amount=credit-price, change_valid=1 only if nonzero, clears credit, -> IDLE.
REQ-027 cancel in IDLE or COLLECT -> REFUND; REFUND drives change_amount=credit, change_valid=1 only if nonzero, clears credit, -> IDLE.
REQ-028 Same-cycle coin and cancel: coin accepted first, refund includes it.
REQ-029 Same cycle credit>=price and cancel in COLLECT: cancel wins.
REQ-030 sel_valid outside IDLE SHALL be ignored without status strobes.
REQ-031 All outputs SHALL be registered; change_amount holds 0 when change_valid=0.

Reset
REQ-032 rst SHALL force IDLE, credit=0, product_sel=00, all strobes 0, change_amount=0, timer=0.
REQ-033 rst mid-transaction SHALL discard credit without refund and without update_inventory.

Configuration
REQ-034 With VEND_TIMEOUT_EN defined, COLLECT SHALL go REFUND after TIMEOUT_CYCLES consecutive cycles without an accepted coin; accepted coin restarts the count.
REQ-035 Without VEND_TIMEOUT_EN, COLLECT SHALL wait indefinitely and no timer logic is present.

Structure
REQ-036 Package vend_pkg SHALL hold the state enum, coin code constants, coin value table (5/10/25) and default prices.
REQ-037 Sub-module vend_timer (load/count/expire) SHALL implement the timeout, instantiated only under VEND_TIMEOUT_EN.

Verification
REQ-038 Select 00 (stock 10), coins 10,10 -> update_inventory+dispense one cycle with product_sel=00, change_amount=5, credit returns 0.
REQ-039 Select 10 with prod3_count=0 -> sold_out one cycle, state IDLE, no update_inventory.
REQ-040 Select 01, coin 10, cancel -> change_valid with change_amount=10, no dispense.
REQ-041 Credit 250, coin 10 -> coin_reject, credit stays 250; coin_code=11 -> coin_reject.
REQ-042 With VEND_TIMEOUT_EN, TIMEOUT_CYCLES=8: select 00, coin 5, idle 8 cycles -> refund 5.
REQ-043 rst asserted in COLLECT with credit 10 -> next cycle IDLE, credit 0, no change_valid.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared state encoding, coin constants, coin values and default prices for the vending controller.
package vend_pkg;

   localparam int unsigned CREDIT_W = 8;
   localparam int unsigned SEL_W    = 2;
   localparam int unsigned COIN_W   = 2;
   localparam int unsigned STOCK_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_VEND,
      S_CHANGE,
      S_REFUND
   } vend_state_t;

   localparam logic [COIN_W-1:0] COIN_5       = 2'b00;
   localparam logic [COIN_W-1:0] COIN_10      = 2'b01;
   localparam logic [COIN_W-1:0] COIN_25      = 2'b10;
   localparam logic [COIN_W-1:0] COIN_INVALID = 2'b11;

   localparam logic [SEL_W-1:0] SEL_INVALID = 2'b11;

   localparam logic [CREDIT_W-1:0] DEF_PRICE1 = 8'd15;
   localparam logic [CREDIT_W-1:0] DEF_PRICE2 = 8'd25;
   localparam logic [CREDIT_W-1:0] DEF_PRICE3 = 8'd30;

   // Coin value table in cents; the invalid code is worth nothing.
   function automatic logic [CREDIT_W-1:0] coin_value(input logic [COIN_W-1:0] code);
      case (code)
         COIN_5:  coin_value = CREDIT_W'(5);
         COIN_10: coin_value = CREDIT_W'(10);
         COIN_25: coin_value = CREDIT_W'(25);
         default: coin_value = '0;
      endcase
   endfunction

   // Stock of the indexed product; the invalid index reads as empty.
   function automatic logic [STOCK_W-1:0] stock_pick(input logic [SEL_W-1:0] idx,
                                                     input logic [STOCK_W-1:0] c1,
                                                     input logic [STOCK_W-1:0] c2,
                                                     input logic [STOCK_W-1:0] c3);
      case (idx)
         2'd0:    stock_pick = c1;
         2'd1:    stock_pick = c2;
         2'd2:    stock_pick = c3;
         default: stock_pick = '0;
      endcase
   endfunction

endpackage

// File: rtl/vend_timer.sv
// COLLECT inactivity timer: load restarts it, count advances it, expire_c flags the LIMIT-th count.
module vend_timer #(
   parameter int unsigned LIMIT = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic count,
   output logic expire_c
);

   localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expire_c = count && !load && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/vend_controller.sv
// Vending controller: product select, coin credit, dispense, change and refund.
// Define VEND_TIMEOUT_EN to refund a COLLECT that sees no accepted coin for TIMEOUT_CYCLES cycles.
module vend_controller
   import vend_pkg::*;
#(
   parameter logic [7:0]  PRICE1         = DEF_PRICE1,
   parameter logic [7:0]  PRICE2         = DEF_PRICE2,
   parameter logic [7:0]  PRICE3         = DEF_PRICE3,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sel_valid,
   input  logic [1:0] sel_id,
   input  logic       coin_valid,
   input  logic [1:0] coin_code,
   input  logic       cancel,
   input  logic [3:0] prod1_count,
   input  logic [3:0] prod2_count,
   input  logic [3:0] prod3_count,
   output logic [1:0] product_sel,
   output logic       update_inventory,
   output logic       dispense,
   output logic       change_valid,
   output logic [7:0] change_amount,
   output logic       coin_reject,
   output logic       sold_out,
   output logic [7:0] credit
);

   vend_state_t state, state_n;

   logic [CREDIT_W-1:0] price, price_n;
   logic [CREDIT_W-1:0] credit_n;
   logic [CREDIT_W-1:0] change_amount_n;
   logic [SEL_W-1:0]    product_sel_n;
   logic                update_n;
   logic                change_valid_n;
   logic                coin_reject_n;
   logic                sold_out_n;

   logic [CREDIT_W:0]   coin_sum_c;
   logic                coin_ok_c;
   logic [STOCK_W-1:0]  sel_stock_c;
   logic [STOCK_W-1:0]  held_stock_c;
   logic [CREDIT_W-1:0] sel_price_c;
   logic                timeout_c;

   // A coin is taken only while shopping and only if the credit cannot overflow.
   assign coin_sum_c   = {1'b0, credit} + {1'b0, coin_value(coin_code)};
   assign coin_ok_c    = coin_valid && (coin_code != COIN_INVALID) && !coin_sum_c[CREDIT_W]
                         && ((state == S_IDLE) || (state == S_COLLECT));
   assign sel_stock_c  = stock_pick(sel_id, prod1_count, prod2_count, prod3_count);
   assign held_stock_c = stock_pick(product_sel, prod1_count, prod2_count, prod3_count);

   always_comb begin
      case (sel_id)
         2'd0:    sel_price_c = PRICE1;
         2'd1:    sel_price_c = PRICE2;
         default: sel_price_c = PRICE3;
      endcase
   end

`ifdef VEND_TIMEOUT_EN
   logic timer_load_c;
   logic timer_count_c;

   assign timer_load_c  = (state != S_COLLECT) || coin_ok_c;
   assign timer_count_c = (state == S_COLLECT);

   vend_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load_c),
      .count    (timer_count_c),
      .expire_c (timeout_c)
   );
`else
   logic unused_timeout_cfg;

   assign timeout_c          = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

   // Next state and next registered outputs.
   always_comb begin
      state_n         = state;
      credit_n        = coin_ok_c ? coin_sum_c[CREDIT_W-1:0] : credit;
      price_n         = price;
      product_sel_n   = product_sel;
      update_n        = 1'b0;
      change_valid_n  = 1'b0;
      change_amount_n = '0;
      sold_out_n      = 1'b0;
      coin_reject_n   = coin_valid && !coin_ok_c;

      case (state)
         S_IDLE: begin
            if (cancel) begin
               state_n = S_REFUND;
            end else if (sel_valid) begin
               if ((sel_id != SEL_INVALID) && (sel_stock_c != '0)) begin
                  product_sel_n = sel_id;
                  price_n       = sel_price_c;
                  state_n       = S_COLLECT;
               end else begin
                  sold_out_n = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            if (cancel) begin
               state_n = S_REFUND;
            end else if (credit >= price) begin
               state_n = S_VEND;
            end else if (timeout_c) begin
               state_n = S_REFUND;
            end
         end
         S_VEND: begin
            // Stock may have drained since selection; refund rather than vend nothing.
            if (held_stock_c == '0) begin
               state_n = S_REFUND;
            end else begin
               update_n = 1'b1;
               state_n  = S_CHANGE;
            end
         end
         S_CHANGE: begin
            change_amount_n = credit - price;
            change_valid_n  = (credit != price);
            credit_n        = '0;
            state_n         = S_IDLE;
         end
         S_REFUND: begin
            change_amount_n = credit;
            change_valid_n  = (credit != '0);
            credit_n        = '0;
            state_n         = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         credit           <= '0;
         price            <= '0;
         product_sel      <= '0;
         update_inventory <= 1'b0;
         dispense         <= 1'b0;
         change_valid     <= 1'b0;
         change_amount    <= '0;
         coin_reject      <= 1'b0;
         sold_out         <= 1'b0;
      end else begin
         state            <= state_n;
         credit           <= credit_n;
         price            <= price_n;
         product_sel      <= product_sel_n;
         update_inventory <= update_n;
         dispense         <= update_n;
         change_valid     <= change_valid_n;
         change_amount    <= change_amount_n;
         coin_reject      <= coin_reject_n;
         sold_out         <= sold_out_n;
      end
   end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed vector table, hand sequences, and random traffic against a model.
module tb_vend_controller;

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 8;
`else
   localparam int unsigned TB_TIMEOUT = 1000;
`endif

   localparam int PRICE [3] = '{15, 25, 30};

   logic       clk;
   logic       rst;
   logic       sel_valid;
   logic [1:0] sel_id;
   logic       coin_valid;
   logic [1:0] coin_code;
   logic       cancel;
   logic [3:0] prod1_count;
   logic [3:0] prod2_count;
   logic [3:0] prod3_count;
   logic [1:0] product_sel;
   logic       update_inventory;
   logic       dispense;
   logic       change_valid;
   logic [7:0] change_amount;
   logic       coin_reject;
   logic       sold_out;
   logic [7:0] credit;

   int n_checks = 0;
   int n_fail   = 0;

   vend_controller #(
      .PRICE1         (8'd15),
      .PRICE2         (8'd25),
      .PRICE3         (8'd30),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .sel_valid        (sel_valid),
      .sel_id           (sel_id),
      .coin_valid       (coin_valid),
      .coin_code        (coin_code),
      .cancel           (cancel),
      .prod1_count      (prod1_count),
      .prod2_count      (prod2_count),
      .prod3_count      (prod3_count),
      .product_sel      (product_sel),
      .update_inventory (update_inventory),
      .dispense         (dispense),
      .change_valid     (change_valid),
      .change_amount    (change_amount),
      .coin_reject      (coin_reject),
      .sold_out         (sold_out),
      .credit           (credit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int rst, sv, sid, cv, cc, can, empty;
      int credit, psel, upd, chv, cha, crej, sout;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t row(input int rst_i, input int sv, input int sid, input int cv,
                                input int cc, input int can, input int empty,
                                input int cr, input int ps, input int upd, input int chv,
                                input int cha, input int crej, input int sout);
      vec_t v;
      v.rst = rst_i; v.sv = sv; v.sid = sid; v.cv = cv; v.cc = cc; v.can = can; v.empty = empty;
      v.credit = cr; v.psel = ps; v.upd = upd; v.chv = chv; v.cha = cha; v.crej = crej; v.sout = sout;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int cr, input int ps, input int upd,
                          input int chv, input int cha, input int crej, input int sout);
      chk({tag, " credit"},           32'(credit),           cr);
      chk({tag, " product_sel"},      32'(product_sel),      ps);
      chk({tag, " update_inventory"}, 32'(update_inventory), upd);
      chk({tag, " dispense"},         32'(dispense),         upd);
      chk({tag, " change_valid"},     32'(change_valid),     chv);
      chk({tag, " change_amount"},    32'(change_amount),    cha);
      chk({tag, " coin_reject"},      32'(coin_reject),      crej);
      chk({tag, " sold_out"},         32'(sold_out),         sout);
   endtask

   // Apply one cycle of inputs (empty bit k zeroes product k+1 stock) and sample after the edge.
   task automatic step(input int r, input int sv, input int sid, input int cv, input int cc,
                       input int can, input int empty);
      rst         = (r != 0);
      sel_valid   = (sv != 0);
      sel_id      = 2'(sid);
      coin_valid  = (cv != 0);
      coin_code   = 2'(cc);
      cancel      = (can != 0);
      prod1_count = ((empty & 1) != 0) ? 4'd0 : 4'd10;
      prod2_count = ((empty & 2) != 0) ? 4'd0 : 4'd10;
      prod3_count = ((empty & 4) != 0) ? 4'd0 : 4'd10;
      @(posedge clk);
      #1;
   endtask

   // Reference model: a purchase moves through shopping, paying, handing over, settling, refunding.
   localparam int M_IDLE   = 0;
   localparam int M_PAY    = 1;
   localparam int M_HAND   = 2;
   localparam int M_SETTLE = 3;
   localparam int M_REFUND = 4;

   int m_phase, m_credit, m_psel, m_quiet;
   int e_credit, e_psel, e_upd, e_chv, e_cha, e_crej, e_sout;

   function automatic int coin_val(input int c);
      case (c)
         0:       return 5;
         1:       return 10;
         2:       return 25;
         default: return 0;
      endcase
   endfunction

   function automatic int stock_of(input int i);
      case (i)
         0:       return int'(prod1_count);
         1:       return int'(prod2_count);
         2:       return int'(prod3_count);
         default: return 0;
      endcase
   endfunction

   task automatic model_step();
      int  val;
      int  next_credit;
      bit  accept;
      e_upd  = 0; e_chv = 0; e_cha = 0; e_crej = 0; e_sout = 0;
      if (rst) begin
         m_phase = M_IDLE; m_credit = 0; m_psel = 0; m_quiet = 0;
      end else begin
         val    = coin_val(int'(coin_code));
         accept = coin_valid && (coin_code != 2'b11) && (m_credit + val <= 255)
                  && (m_phase == M_IDLE || m_phase == M_PAY);
         e_crej = (coin_valid && !accept) ? 1 : 0;
         next_credit = accept ? m_credit + val : m_credit;
         case (m_phase)
            M_IDLE: begin
               if (cancel) m_phase = M_REFUND;
               else if (sel_valid) begin
                  if (sel_id != 2'b11 && stock_of(int'(sel_id)) > 0) begin
                     m_psel = int'(sel_id); m_phase = M_PAY; m_quiet = 0;
                  end else e_sout = 1;
               end
            end
            M_PAY: begin
               m_quiet = accept ? 0 : m_quiet + 1;
               if (cancel) m_phase = M_REFUND;
               else if (m_credit >= PRICE[m_psel]) m_phase = M_HAND;
`ifdef VEND_TIMEOUT_EN
               else if (m_quiet >= int'(TB_TIMEOUT)) m_phase = M_REFUND;
`endif
            end
            M_HAND: begin
               if (stock_of(m_psel) == 0) m_phase = M_REFUND;
               else begin e_upd = 1; m_phase = M_SETTLE; end
            end
            M_SETTLE: begin
               e_cha = m_credit - PRICE[m_psel];
               e_chv = (e_cha != 0) ? 1 : 0;
               next_credit = 0; m_phase = M_IDLE;
            end
            default: begin
               e_cha = m_credit;
               e_chv = (e_cha != 0) ? 1 : 0;
               next_credit = 0; m_phase = M_IDLE;
            end
         endcase
         m_credit = next_credit;
      end
      e_credit = m_credit;
      e_psel   = m_psel;
   endtask

   function automatic logic [3:0] rand_stock();
      return ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
   endfunction

   initial begin
      int n;
      rst = 1'b1; sel_valid = 1'b0; sel_id = 2'd0; coin_valid = 1'b0; coin_code = 2'd0;
      cancel = 1'b0; prod1_count = 4'd10; prod2_count = 4'd10; prod3_count = 4'd10;

      //                 rst sv sid cv cc can emp | cr ps upd chv cha crej sout
      vecs.push_back(row(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 1, 1, 0, 0,  10, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 1, 1, 0, 0,  20, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,  20, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,  20, 0, 1, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 5,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 1, 2, 0, 0, 0, 4,   0, 0, 0, 0, 0,  0, 1));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 4,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 1, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 1));
      vecs.push_back(row(0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 1, 1, 0, 0,  10, 1, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 1, 0,  10, 1, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 10, 0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 1, 2, 0, 0, 0, 0,   0, 2, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 1, 2, 1, 0,  25, 2, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 1, 25, 0, 0));
      vecs.push_back(row(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 1, 2, 0, 0,  25, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 1, 0,  25, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 25, 0, 0));
      vecs.push_back(row(0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 1, 2, 0, 0,  25, 1, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 2,  25, 1, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 1, 0, 0, 2,  25, 1, 0, 0, 0,  1, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 2,   0, 1, 0, 1, 25, 0, 0));
      vecs.push_back(row(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 1, 1, 0, 0,  10, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 1, 0, 0, 0,  15, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,  15, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,  15, 0, 1, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 1, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 0, 0, 1, 1, 0, 0,  10, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0));
      vecs.push_back(row(0, 1, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 1));
      vecs.push_back(row(0, 0, 0, 1, 3, 0, 0,   0, 0, 0, 0, 0,  1, 0));
      vecs.push_back(row(0, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0,  0, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].sv, vecs[i].sid, vecs[i].cv, vecs[i].cc, vecs[i].can,
              vecs[i].empty);
         chk_all($sformatf("vec%0d", i), vecs[i].credit, vecs[i].psel, vecs[i].upd,
                 vecs[i].chv, vecs[i].cha, vecs[i].crej, vecs[i].sout);
      end

      // Credit ceiling: quarters in IDLE up to 250, then overflow and invalid coins.
      for (int k = 1; k <= 10; k++) begin
         step(0, 0, 0, 1, 2, 0, 0);
         chk_all($sformatf("fill%0d", k), 25 * k, 0, 0, 0, 0, 0, 0);
      end
      step(0, 0, 0, 1, 1, 0, 0);
      chk_all("ovf_dime", 250, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      chk_all("nickel_fits", 255, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      chk_all("ovf_nickel", 255, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      chk_all("cancel_full", 255, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk_all("refund_full", 0, 0, 0, 1, 255, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk_all("after_refund", 0, 0, 0, 0, 0, 0, 0);

`ifdef VEND_TIMEOUT_EN
      // Select, one nickel, then silence: refund appears on the ninth quiet cycle.
      step(0, 1, 0, 0, 0, 0, 0);
      chk_all("to_select", 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      chk_all("to_coin", 5, 0, 0, 0, 0, 0, 0);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         step(0, 0, 0, 0, 0, 0, 0);
         if (change_valid && n == 0) n = k;
      end
      chk("timeout_latency", 32'(n), 32'd9);
      chk("timeout_credit", 32'(credit), 32'd0);
`endif

      // Random traffic checked cycle by cycle against the model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst        = (cyc == 0) || ($urandom_range(0, 299) == 0);
         sel_valid  = ($urandom_range(0, 5) == 0);
         sel_id     = 2'($urandom_range(0, 3));
         coin_valid = ($urandom_range(0, 2) == 0);
         coin_code  = 2'($urandom_range(0, 3));
         cancel     = ($urandom_range(0, 39) == 0);
         if (cyc % 40 == 0) begin
            prod1_count = rand_stock();
            prod2_count = rand_stock();
            prod3_count = rand_stock();
         end
         model_step();
         @(posedge clk);
         #1;
         chk_all($sformatf("rnd%0d", cyc), e_credit, e_psel, e_upd, e_chv, e_cha, e_crej, e_sout);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
